// File: rtl/multiplier_2x2.sv
// Unsigned WIDTH x WIDTH array multiplier (AND partial products + ripple-carry rows)
// with registered product and valid flag. Define MULTIPLIER_PIPE_EN to add an operand register stage.

module mul_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module mul_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module multiplier_2x2 #(
  parameter int WIDTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] P
);

  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               op_valid;
  logic [2*WIDTH-1:0] prod;

`ifdef MULTIPLIER_PIPE_EN
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             vin_q, vin_d;

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    vin_d = in_valid;
    if (in_valid) begin
      a_d = A;
      b_d = B;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      vin_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      vin_q <= vin_d;
    end
  end

  assign op_a     = a_q;
  assign op_b     = b_q;
  assign op_valid = vin_q;
`else
  assign op_a     = A;
  assign op_b     = B;
  assign op_valid = in_valid;
`endif

  logic [WIDTH-1:0] pp    [WIDTH];
  // acc[r] is the shifted running sum entering adder row r+1
  logic [WIDTH-1:0] acc   [WIDTH-1];
  logic [WIDTH-1:0] row_s [WIDTH-1];
  logic [WIDTH-1:0] row_c [WIDTH-1];

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp
    assign pp[gi] = op_a & {WIDTH{op_b[gi]}};
  end

  assign acc[0]  = {1'b0, pp[0][WIDTH-1:1]};
  assign prod[0] = pp[0][0];

  for (genvar r = 0; r < WIDTH - 1; r++) begin : g_row
    for (genvar j = 0; j < WIDTH; j++) begin : g_cell
      if (j == 0) begin : g_ha
        mul_ha u_ha (
          .a (acc[r][0]),
          .b (pp[r+1][0]),
          .s (row_s[r][0]),
          .c (row_c[r][0])
        );
      end else begin : g_fa
        mul_fa u_fa (
          .a  (acc[r][j]),
          .b  (pp[r+1][j]),
          .ci (row_c[r][j-1]),
          .s  (row_s[r][j]),
          .co (row_c[r][j])
        );
      end
    end
    assign prod[r+1] = row_s[r][0];
    if (r < WIDTH - 2) begin : g_next
      assign acc[r+1] = {row_c[r][WIDTH-1], row_s[r][WIDTH-1:1]};
    end
  end

  assign prod[2*WIDTH-2:WIDTH] = row_s[WIDTH-2][WIDTH-1:1];
  assign prod[2*WIDTH-1]       = row_c[WIDTH-2][WIDTH-1];

  logic [2*WIDTH-1:0] p_q, p_d;
  logic               out_valid_q, out_valid_d;

  always_comb begin
    p_d         = p_q;
    out_valid_d = op_valid;
    if (op_valid) p_d = prod;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign P         = p_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multiplier_2x2.sv
// Scoreboard bench for multiplier_2x2: a WIDTH=2 reference instance and a WIDTH=8 instance.
// Expected products and due cycles are queued at issue time and popped by negedge monitors.

module tb_multiplier_2x2;

`ifdef MULTIPLIER_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [15:0] p;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vin2 = 1'b0;
  logic [1:0]  a2 = '0;
  logic [1:0]  b2 = '0;
  logic        ov2;
  logic [3:0]  p2;
  logic        vin8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        ov8;
  logic [15:0] p8;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q2[$];
  exp_t q8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multiplier_2x2 #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(vin2), .A(a2), .B(b2), .out_valid(ov2), .P(p2)
  );

  multiplier_2x2 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(vin8), .A(a8), .B(b8), .out_valid(ov8), .P(p8)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ov2) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w2_unexpected_valid: got out_valid=1 P=%0d expected no output (t=%0t)", p2, $time);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("w2_product", int'(p2), int'(e.p));
        chk("w2_latency_cycle", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov8) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w8_unexpected_valid: got out_valid=1 P=%0d expected no output (t=%0t)", p8, $time);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("w8_product", int'(p8), int'(e.p));
        chk("w8_latency_cycle", cyc, e.due);
      end
    end
  end

  task automatic issue2(input int a, input int b, input int prod);
    exp_t e;
    @(posedge clk);
    #1;
    vin2 = 1'b1;
    a2   = 2'(a);
    b2   = 2'(b);
    e.p   = 16'(prod);
    e.due = cyc + LAT;
    q2.push_back(e);
  endtask

  task automatic issue8(input int a, input int b, input int prod);
    exp_t e;
    @(posedge clk);
    #1;
    vin8 = 1'b1;
    a8   = 8'(a);
    b8   = 8'(b);
    e.p   = 16'(prod);
    e.due = cyc + LAT;
    q8.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      vin2 = 1'b0;
      vin8 = 1'b0;
    end
  endtask

  // Exhaustive WIDTH=2 table, products hand-computed: index = a*4 + b
  int sweep_p [16] = '{0,0,0,0, 0,1,2,3, 0,2,4,6, 0,3,6,9};

  initial begin
    #2;
    chk("reset_P", int'(p2), 0);
    chk("reset_out_valid", int'(ov2), 0);
    #20 rst_n = 1'b1;
    idle(2);

    issue2(2, 2, 4); idle(3);
    issue2(1, 2, 2); idle(3);
    issue2(2, 3, 6); idle(3);
    issue2(3, 1, 3); idle(3);
    issue2(1, 1, 1); idle(3);

    issue2(3, 3, 9); idle(3);
    issue2(0, 3, 0); idle(3);
    issue2(3, 0, 0); idle(3);

    issue2(2, 2, 4);
    issue2(3, 2, 6);
    issue2(2, 1, 2);
    issue2(3, 3, 9);
    idle(4);

    issue2(3, 2, 6);
    idle(LAT + 3);
    @(negedge clk);
    chk("idle_hold_P", int'(p2), 6);
    chk("idle_hold_out_valid", int'(ov2), 0);

    for (int i = 0; i < 16; i++) issue2(i / 4, i % 4, sweep_p[i]);
    idle(4);

    issue2(2, 3, 6);
    issue2(3, 3, 9);
    #2;
    rst_n = 1'b0;
    vin2  = 1'b0;
    #1;
    chk("midrun_reset_P", int'(p2), 0);
    chk("midrun_reset_out_valid", int'(ov2), 0);
    q2.delete();
    q8.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    idle(5);
    issue2(1, 1, 1);
    idle(4);

    issue8(255, 255, 65025);
    issue8(0, 200, 0);
    issue8(200, 0, 0);
    issue8(15, 17, 255);
    issue8(128, 2, 256);
    issue8(170, 85, 14450);
    for (int i = 0; i < 24; i++) begin
      int ra;
      int rb;
      ra = int'($urandom_range(255));
      rb = int'($urandom_range(255));
      issue8(ra, rb, ra * rb);
    end
    idle(2);

    begin
      int budget;
      budget = 0;
      while ((q2.size() != 0 || q8.size() != 0) && budget < 20) begin
        @(posedge clk);
        budget++;
      end
    end
    @(negedge clk);
    chk("w2_queue_drained", q2.size(), 0);
    chk("w8_queue_drained", q8.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
